rgb_pwm_driver: RTL and testbench

Consumer end of the RGB colour path: accepts 8-bit R/G/B intensity words from the colour processor over a valid/ready handshake and drives three LED PWM outputs. A new colour is held in a pending buffer and applied only at a PWM period boundary, so no glitched partial periods appear at the LEDs. The block sits between the RGB processor outputs and the board LED pins.

---
 rtl/rgb_pkg.sv | 19 +
 rtl/rgb_pwm_driver_if.sv | 28 ++
 rtl/pwm_channel.sv | 32 +++
 rtl/rgb_pwm_driver.sv | 140 ++++++++++++++
 tb/tb_rgb_pwm_driver.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rgb_pkg.sv
// Shared types and constants for the RGB PWM driver: channel width, PWM full-scale
// value, FSM state encoding and the packed colour triple.
package rgb_pkg;

    localparam int unsigned RGB_WIDTH = 8;
    localparam int unsigned PWM_MAX   = (1 << RGB_WIDTH) - 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic [RGB_WIDTH-1:0] r;
        logic [RGB_WIDTH-1:0] g;
        logic [RGB_WIDTH-1:0] b;
    } rgb_t;

endpackage

// File: rtl/rgb_pwm_driver_if.sv
// Colour handshake from the colour processor (master) into the PWM driver (slave).
interface rgb_pwm_driver_if #(
    parameter int unsigned WIDTH = 8
);

    logic [WIDTH-1:0] r_in;
    logic [WIDTH-1:0] g_in;
    logic [WIDTH-1:0] b_in;
    logic             in_valid;
    logic             in_ready;

    modport master (
        output r_in,
        output g_in,
        output b_in,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  r_in,
        input  g_in,
        input  b_in,
        input  in_valid,
        output in_ready
    );

endinterface

// File: rtl/pwm_channel.sv
// One LED channel: registered compare of the shared tick counter against this
// channel's active duty.
module pwm_channel #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] duty_i,
    input  logic [WIDTH-1:0] tick_i,
    input  logic             run_i,
    output logic             pwm_o
);

    logic pwm_q;
    logic pwm_d;

    // Unsigned compare: duty 0 never fires, duty 2^WIDTH-1 covers every tick value.
    assign pwm_d = run_i && (tick_i < duty_i);

    // NOTE: clocked state uses non-blocking assignments so every register samples
    // pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_q <= 1'b0;
        end else begin
            pwm_q <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/rgb_pwm_driver.sv
// RGB LED PWM driver: accepts colours over valid/ready into a one-deep pending
// buffer and applies them only at PWM period boundaries to avoid glitched periods.
module rgb_pwm_driver
    import rgb_pkg::*;
#(
    parameter int unsigned PRESCALE = 4,
    // Channel width is fixed by rgb_t; keep WIDTH equal to RGB_WIDTH.
    parameter int unsigned WIDTH    = RGB_WIDTH
) (
    input  logic            clk,
    input  logic            rst_n,
    rgb_pwm_driver_if.slave in_if,
    input  logic            enable,
    output logic            pwm_r,
    output logic            pwm_g,
    output logic            pwm_b,
    output logic            period_start
);

    localparam logic [15:0]      PRESC_LAST = 16'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] TICK_LAST  = WIDTH'((1 << WIDTH) - 2);

    state_e           state_q, state_d;
    logic [15:0]      presc_q, presc_d;
    logic [WIDTH-1:0] tick_q, tick_d;
    logic             pend_q, pend_d;
    rgb_t             pend_rgb_q, pend_rgb_d;
    rgb_t             act_q, act_d;
    logic             period_start_q, period_start_d;
    logic             accept;
    logic             apply;
    logic             run;

    // A full pending buffer holds off the producer; no accept can collide with apply.
    assign accept          = in_if.in_valid && !pend_q;
    assign in_if.in_ready  = !pend_q;
    assign run             = (state_q == RUN);

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves a
        // signal unassigned and no latch is inferred.
        state_d    = state_q;
        presc_d    = presc_q;
        tick_d     = tick_q;
        pend_d     = pend_q;
        pend_rgb_d = pend_rgb_q;
        act_d      = act_q;
        apply      = 1'b0;

        unique case (state_q)
            IDLE: begin
                presc_d = '0;
                tick_d  = '0;
                apply   = pend_q;
                if (enable) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_d = IDLE;
                    presc_d = '0;
                    tick_d  = '0;
                end else if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        apply  = pend_q;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end else begin
                    presc_d = presc_q + 16'd1;
                end
            end
        endcase

        if (apply) begin
            act_d  = pend_rgb_q;
            pend_d = 1'b0;
        end
        if (accept) begin
            pend_rgb_d = '{r: in_if.r_in, g: in_if.g_in, b: in_if.b_in};
            pend_d     = 1'b1;
        end
    end

    // First cycle of a period; registered so it lines up with the first pwm output.
    assign period_start_d = run && (presc_q == '0) && (tick_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            presc_q        <= '0;
            tick_q         <= '0;
            pend_q         <= 1'b0;
            pend_rgb_q     <= '0;
            act_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            presc_q        <= presc_d;
            tick_q         <= tick_d;
            pend_q         <= pend_d;
            pend_rgb_q     <= pend_rgb_d;
            act_q          <= act_d;
            period_start_q <= period_start_d;
        end
    end

    assign period_start = period_start_q;

    pwm_channel #(.WIDTH(WIDTH)) u_chan_r (
        .clk    (clk),
        .rst_n  (rst_n),
        .duty_i (act_q.r),
        .tick_i (tick_q),
        .run_i  (run),
        .pwm_o  (pwm_r)
    );

    pwm_channel #(.WIDTH(WIDTH)) u_chan_g (
        .clk    (clk),
        .rst_n  (rst_n),
        .duty_i (act_q.g),
        .tick_i (tick_q),
        .run_i  (run),
        .pwm_o  (pwm_g)
    );

    pwm_channel #(.WIDTH(WIDTH)) u_chan_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .duty_i (act_q.b),
        .tick_i (tick_q),
        .run_i  (run),
        .pwm_o  (pwm_b)
    );

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Bench for rgb_pwm_driver: a period-level reference model predicts the colour of
// every PWM period; a monitor measures each period at the pins and scores it.
module tb_rgb_pwm_driver;
    import rgb_pkg::*;

    localparam int PRESCALE = 4;
    localparam int WIDTH    = RGB_WIDTH;
    localparam int PERIOD   = PWM_MAX * PRESCALE;

    logic clk;
    logic rst_n;
    logic enable;
    logic pwm_r, pwm_g, pwm_b, period_start;

    rgb_pwm_driver_if #(.WIDTH(WIDTH)) in_if ();

    rgb_pwm_driver #(.PRESCALE(PRESCALE), .WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_if        (in_if),
        .enable       (enable),
        .pwm_r        (pwm_r),
        .pwm_g        (pwm_g),
        .pwm_b        (pwm_b),
        .period_start (period_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: position within the period, pending slot and active colour.
    bit   m_run;
    int   m_phase;
    bit   m_pend_v;
    rgb_t m_pend;
    rgb_t m_act;
    rgb_t exp_q[$];
    bit   win_aborted;

    task automatic model_step();
        bit pend_pre;
        bit apply;
        bit push;
        if (!rst_n) begin
            m_run = 0; m_phase = 0; m_pend_v = 0; m_pend = '0; m_act = '0;
            exp_q.delete();
            win_aborted = 1;
            return;
        end
        pend_pre = m_pend_v;
        apply    = 0;
        push     = 0;
        if (!m_run) begin
            apply = pend_pre;
            if (enable) begin
                m_run = 1; m_phase = 0; push = 1;
            end
        end else if (!enable) begin
            m_run = 0; m_phase = 0; win_aborted = 1;
        end else begin
            m_phase = (m_phase + 1) % PERIOD;
            if (m_phase == 0) begin
                apply = pend_pre; push = 1;
            end
        end
        if (apply) begin
            m_act = m_pend; m_pend_v = 0;
        end
        if (in_if.in_valid && !pend_pre) begin
            m_pend   = '{r: in_if.r_in, g: in_if.g_in, b: in_if.b_in};
            m_pend_v = 1;
        end
        if (push) exp_q.push_back(m_act);
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    // Monitor: one window per period_start pulse, scored when the next one arrives.
    bit   win_open = 0;
    rgb_t win_exp;
    int   win_len, cnt_r, cnt_g, cnt_b;

    task automatic monitor_step();
        if (!rst_n) begin
            win_open = 0;
            return;
        end
        if (in_if.in_valid) check("in_ready", int'(in_if.in_ready), int'(!m_pend_v));
        if (period_start) begin
            if (win_open && !win_aborted) begin
                check("period_len", win_len, PERIOD);
                check("duty_r", cnt_r, int'(win_exp.r) * PRESCALE);
                check("duty_g", cnt_g, int'(win_exp.g) * PRESCALE);
                check("duty_b", cnt_b, int'(win_exp.b) * PRESCALE);
            end
            win_aborted = 0;
            check("sb_expected_period", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) win_exp = exp_q.pop_front();
            else win_aborted = 1;
            win_open = 1;
            win_len  = 0; cnt_r = 0; cnt_g = 0; cnt_b = 0;
        end
        if (win_open) begin
            win_len++;
            cnt_r += int'(pwm_r);
            cnt_g += int'(pwm_g);
            cnt_b += int'(pwm_b);
        end
    endtask

    initial forever begin
        @(negedge clk);
        monitor_step();
    end

    // Stimulus helpers, all called on the falling edge.
    task automatic offer(input rgb_t c);
        bit ok;
        bit rdy;
        in_if.r_in     = c.r;
        in_if.g_in     = c.g;
        in_if.b_in     = c.b;
        in_if.in_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 3 * PERIOD; i++) begin
            rdy = in_if.in_ready;
            @(negedge clk);
            if (rdy) begin
                ok = 1;
                break;
            end
        end
        in_if.in_valid = 1'b0;
        check("offer_accepted", int'(ok), 1);
    endtask

    task automatic wait_phase(input int ph);
        for (int i = 0; i < 2 * PERIOD; i++) begin
            if (m_run && m_phase == ph) break;
            @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic rgb_t rand_rgb();
        rgb_t c;
        c.r = WIDTH'($urandom);
        c.g = WIDTH'($urandom);
        c.b = WIDTH'($urandom);
        return c;
    endfunction

    initial begin
        #(60000 * 10);
        $display("FAIL watchdog: simulation did not complete, checks %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rgb_t c;
        rst_n          = 1'b0;
        enable         = 1'b0;
        in_if.in_valid = 1'b0;
        in_if.r_in     = '0;
        in_if.g_in     = '0;
        in_if.b_in     = '0;
        idle(2);
        check("rst_pwm_r", int'(pwm_r), 0);
        check("rst_pwm_g", int'(pwm_g), 0);
        check("rst_pwm_b", int'(pwm_b), 0);
        check("rst_period_start", int'(period_start), 0);
        check("rst_in_ready", int'(in_if.in_ready), 1);
        rst_n = 1'b1;

        // Running with nothing accepted: dark LEDs, regular period_start.
        enable = 1'b1;
        idle(3 * PERIOD + 5);
        check("noc_in_ready", int'(in_if.in_ready), 1);

        // Colour loaded while idle, applied on entering RUN.
        enable = 1'b0;
        idle(3);
        offer('{r: 8'd255, g: 8'd0, b: 8'd128});
        idle(3);
        check("idle_pwm_r_low", int'(pwm_r), 0);
        enable = 1'b1;
        idle(2 * PERIOD + 5);

        // Back-to-back colours: B waits for A to apply at the boundary.
        wait_phase(200);
        offer('{r: 8'd10, g: 8'd10, b: 8'd10});
        offer(rand_rgb());
        idle(2 * PERIOD + 5);

        // Randomly timed colours.
        for (int i = 0; i < 4; i++) begin
            idle($urandom_range(1, PERIOD));
            offer(rand_rgb());
        end
        idle(2 * PERIOD + 5);

        // Accept on the boundary edge itself with the pending slot empty.
        wait_phase(PERIOD - 1);
        c   = rand_rgb();
        c.r = 8'd255;
        offer(c);
        idle(2 * PERIOD + 5);

        // Drop enable mid-period, then re-enable.
        wait_phase(300);
        enable = 1'b0;
        idle(2);
        check("drop_pwm_r", int'(pwm_r), 0);
        check("drop_pwm_g", int'(pwm_g), 0);
        check("drop_pwm_b", int'(pwm_b), 0);
        enable = 1'b1;
        idle(PERIOD + 400);

        // Single-cycle enable glitch restarts the period.
        enable = 1'b0;
        idle(1);
        enable = 1'b1;
        idle(2 * PERIOD + 5);

        // Asynchronous reset mid-period with a colour pending.
        wait_phase(10);
        offer(rand_rgb());
        idle(100);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_pwm_r", int'(pwm_r), 0);
        check("arst_pwm_g", int'(pwm_g), 0);
        check("arst_pwm_b", int'(pwm_b), 0);
        check("arst_period_start", int'(period_start), 0);
        check("arst_in_ready", int'(in_if.in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        check("post_rst_in_ready", int'(in_if.in_ready), 1);
        idle(2 * PERIOD + 5);

        enable = 1'b0;
        idle(5);
        check("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
